// File: rtl/uart_rx.sv
// UART receiver: 8 data bits MSB first, one stop bit, CLKS_PER_BIT clocks per bit.
// One-entry output register with a valid/ready handshake plus framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned Half       = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] BitReload  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfReload = (Half > 0) ? 16'(Half - 1) : 16'd0;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          // With no half-bit delay the detection cycle doubles as the start verify.
          if (Half == 0) begin
            state_d   = StData;
            cnt_d     = BitReload;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = StStart;
            cnt_d   = HalfReload;
          end
        end
      end
      StStart: begin
        if (cnt_q == 16'd0) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            cnt_d     = BitReload;
            bit_cnt_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == 16'd0) begin
          shift_d   = {shift_q[6:0], rx_s_q};
          cnt_d     = BitReload;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == 16'd0) begin
          if (rx_s_q) begin
            state_d = StIdle;
            // A same-cycle handshake frees the slot for the new byte.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1, 4 and 8 clocks per bit; output monitors feed the checks.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst4, rst8;
  logic       rx1, rx4, rx8;
  logic       rdy1, rdy4, rdy8;
  logic [7:0] d1, d4, d8;
  logic       v1, v4, v8;
  logic       fe1, fe4, fe8;
  logic       ov1, ov4, ov8;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .CLK(clk), .RESET(rst1), .rx(rx1), .data(d1), .valid(v1), .ready(rdy1),
    .framing_error(fe1), .overrun(ov1)
  );
  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .CLK(clk), .RESET(rst4), .rx(rx4), .data(d4), .valid(v4), .ready(rdy4),
    .framing_error(fe4), .overrun(ov4)
  );
  uart_rx #(.CLKS_PER_BIT(8)) dut8 (
    .CLK(clk), .RESET(rst8), .rx(rx8), .data(d8), .valid(v8), .ready(rdy8),
    .framing_error(fe8), .overrun(ov8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-instance event monitor, index 0/1/2 = N of 1/4/8
  int         rises[3] = '{0, 0, 0};
  int         hs[3]    = '{0, 0, 0};
  int         vhigh[3] = '{0, 0, 0};
  int         fes[3]   = '{0, 0, 0};
  int         ovs[3]   = '{0, 0, 0};
  int         both[3]  = '{0, 0, 0};
  logic       vprev[3] = '{1'b0, 1'b0, 1'b0};
  int         rise_cyc[3][4];
  logic [7:0] rise_dat[3][4];

  task automatic mon(input int s, input logic v, input logic [7:0] d, input logic r,
                     input logic fe, input logic ov);
    if (v && !vprev[s]) begin
      if (rises[s] < 4) begin
        rise_cyc[s][rises[s]] = cyc;
        rise_dat[s][rises[s]] = d;
      end
      rises[s]++;
    end
    vprev[s] = v;
    if (v) vhigh[s]++;
    if (v && r) hs[s]++;
    if (fe) fes[s]++;
    if (ov) ovs[s]++;
    if (fe && ov) both[s]++;
  endtask

  always @(negedge clk) begin
    mon(0, v1, d1, rdy1, fe1, ov1);
    mon(1, v4, d4, rdy4, fe4, ov4);
    mon(2, v8, d8, rdy8, fe8, ov8);
  end

  task automatic clear_mon();
    for (int s = 0; s < 3; s++) begin
      rises[s] = 0;
      hs[s]    = 0;
      vhigh[s] = 0;
      fes[s]   = 0;
      ovs[s]   = 0;
      both[s]  = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int s, input logic b);
    case (s)
      0:       rx1 = b;
      1:       rx4 = b;
      default: rx8 = b;
    endcase
  endtask

  // Line is left at the stop-bit level when the frame ends.
  task automatic send_frame(input int s, input int n, input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {1'b0, b, stop};
    for (int i = 9; i >= 0; i--) begin
      set_rx(s, f[i]);
      step(n);
    end
  endtask

  int c;

  initial begin
    rx1 = 1'b1; rx4 = 1'b1; rx8 = 1'b1;
    rdy1 = 1'b1; rdy4 = 1'b1; rdy8 = 1'b1;
    rst1 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
    step(3);
    check_eq("reset_data", {24'd0, d1}, 32'h00);
    check_eq("reset_valid", {31'd0, v1}, 32'd0);
    check_eq("reset_fe", {31'd0, fe1}, 32'd0);
    check_eq("reset_ov", {31'd0, ov1}, 32'd0);
    check_eq("reset_valid_n8", {31'd0, v8}, 32'd0);
    rst1 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
    step(3);

    // Single frame, N=1: valid 12 cycles after the start bit
    clear_mon();
    c = cyc;
    send_frame(0, 1, 8'hA5, 1'b1);
    step(8);
    check_eq("a5_rises", rises[0], 1);
    check_eq("a5_latency", rise_cyc[0][0], c + 12);
    check_eq("a5_data", {24'd0, rise_dat[0][0]}, 32'hA5);
    check_eq("a5_width", vhigh[0], 1);
    check_eq("a5_no_fe", fes[0], 0);
    check_eq("a5_no_ov", ovs[0], 0);

    // Back-to-back frames with zero idle gap
    clear_mon();
    c = cyc;
    send_frame(0, 1, 8'h3C, 1'b1);
    send_frame(0, 1, 8'hC3, 1'b1);
    step(8);
    check_eq("b2b_rises", rises[0], 2);
    check_eq("b2b_first_cyc", rise_cyc[0][0], c + 12);
    check_eq("b2b_spacing", rise_cyc[0][1] - rise_cyc[0][0], 10);
    check_eq("b2b_data0", {24'd0, rise_dat[0][0]}, 32'h3C);
    check_eq("b2b_data1", {24'd0, rise_dat[0][1]}, 32'hC3);

    // N=4: stop bit low, long break, then recovery
    clear_mon();
    send_frame(1, 4, 8'h81, 1'b0);
    step(20);
    set_rx(1, 1'b1);
    step(10);
    check_eq("brk_fe_count", fes[1], 1);
    check_eq("brk_no_valid", rises[1], 0);
    send_frame(1, 4, 8'h55, 1'b1);
    step(10);
    check_eq("brk_rx_rises", rises[1], 1);
    check_eq("brk_rx_data", {24'd0, rise_dat[1][0]}, 32'h55);
    check_eq("brk_no_ov", ovs[1], 0);
    check_eq("brk_fe_ov_apart", both[1], 0);

    // Overrun: consumer stalled across two frames
    clear_mon();
    rdy1 = 1'b0;
    send_frame(0, 1, 8'h11, 1'b1);
    send_frame(0, 1, 8'h22, 1'b1);
    step(6);
    check_eq("ovr_valid_held", {31'd0, v1}, 32'd1);
    check_eq("ovr_data_held", {24'd0, d1}, 32'h11);
    check_eq("ovr_pulse_count", ovs[0], 1);
    check_eq("ovr_rises", rises[0], 1);
    check_eq("ovr_no_fe", fes[0], 0);
    rdy1 = 1'b1;
    step(2);
    check_eq("ovr_valid_clear", {31'd0, v1}, 32'd0);
    check_eq("ovr_handshakes", hs[0], 1);

    // N=8: short low glitch while idle is rejected
    clear_mon();
    set_rx(2, 1'b0);
    step(2);
    set_rx(2, 1'b1);
    step(30);
    check_eq("glitch_no_valid", rises[2], 0);
    check_eq("glitch_no_fe", fes[2], 0);
    check_eq("glitch_no_ov", ovs[2], 0);
    send_frame(2, 8, 8'hF0, 1'b1);
    step(20);
    check_eq("glitch_next_rises", rises[2], 1);
    check_eq("glitch_next_data", {24'd0, rise_dat[2][0]}, 32'hF0);

    // Reset in the middle of a frame, then a clean frame
    clear_mon();
    set_rx(0, 1'b0);
    step(1);
    set_rx(0, 1'b1);
    step(4);
    rst1 = 1'b1;
    step(2);
    rst1 = 1'b0;
    step(3);
    check_eq("rst_abort_no_valid", rises[0], 0);
    check_eq("rst_abort_data", {24'd0, d1}, 32'h00);
    send_frame(0, 1, 8'h0F, 1'b1);
    step(8);
    check_eq("rst_next_rises", rises[0], 1);
    check_eq("rst_next_data", {24'd0, rise_dat[0][0]}, 32'h0F);
    check_eq("rst_no_fe", fes[0], 0);
    check_eq("rst_no_ov", ovs[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit; legal range 1..65535; default matches the one-bit-per-clock UART transmitter.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset; sampled only on the rising edge of CLK.
REQ-004 rx  input  1  serial line; idle high; frame is 1 start bit (0), 8 data bits MSB first, 1 stop bit (1).
REQ-005 data  output  8  received byte; stable while valid=1.
REQ-006 valid  output  1  data holds an unconsumed byte.
REQ-007 ready  input  1  consumer accepts data on a cycle where valid=1 and ready=1.
REQ-008 framing_error  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-009 overrun  output  1  one-cycle pulse: completed byte dropped because the output was still full.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; rx_s is the second flop's output; all decisions SHALL use rx_s only.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 Let H=(CLKS_PER_BIT-1)/2 (integer division) and N=CLKS_PER_BIT; t0 is the first cycle in IDLE with rx_s=0.
REQ-013 Start verify SHALL occur at t0+H; if rx_s=1 there, the FSM SHALL return to IDLE with no output activity (glitch reject).
REQ-014 Data bit k (k=0..7, k=0 is MSB) SHALL be sampled at t0+H+(k+1)*N; the stop bit SHALL be sampled at t0+H+9*N.
REQ-015 For N=1, the start verify SHALL be the t0 detection itself; bits are sampled at t0+1..t0+8 and stop at t0+9.
REQ-016 Baud counter SHALL be 16 bits, reload at 0 after each sample, and never wrap within a frame.
REQ-017 Stop=1: the FSM SHALL be in IDLE on the cycle after the stop sample and able to detect a new start bit that cycle (back-to-back frames, zero idle gap).
REQ-018 Stop=0: framing_error SHALL pulse on the cycle after the stop sample; the byte SHALL be discarded; the FSM SHALL enter BREAK.
REQ-019 BREAK SHALL remain until rx_s=1, then go to IDLE on the next cycle.
REQ-020 Output load: on the edge ending the stop-sample cycle with stop=1, data SHALL load and valid SHALL set if valid=0 or (valid=1 and ready=1) in that cycle.
REQ-021 Otherwise the new byte SHALL be dropped, data and valid SHALL keep the old byte, and overrun SHALL pulse on the next cycle.
REQ-022 valid SHALL clear on the edge after a cycle with valid=1 and ready=1, unless a load occurs on that same edge (REQ-020).
REQ-023 End-to-end latency for N=1: a start bit driven on rx at cycle c SHALL give valid=1 at c+12.
REQ-024 framing_error and overrun SHALL never be high in the same cycle as each other for the same frame; each SHALL be high for exactly one cycle per event.

Reset
REQ-025 While RESET=1 at an edge, the following SHALL be set: synchronizer flops=1, state=IDLE, counters=0, data=8'h00, valid=0, framing_error=0, overrun=0.
REQ-026 RESET asserted mid-frame SHALL abort the frame with no valid, framing_error or overrun output.
REQ-027 After release, reception SHALL start with the first falling edge of rx_s; a low level on rx at release SHALL be detected as a start bit.

Verification
REQ-028 N=1, ready=1: send frame 0xA5 starting at cycle c -> valid=1 and data=8'hA5 at c+12, one cycle wide; no error pulses.
REQ-029 N=1: send back-to-back frames 0x3C,0xC3 with zero gap and ready=1 -> two valid pulses exactly 10 cycles apart with data 3C then C3.
REQ-030 N=4: send 0x81 with stop bit forced 0, then hold rx=0 for 20 cycles, then release -> one framing_error pulse, no valid; the next frame 0x55 is received correctly.
REQ-031 N=1, ready=0: send 0x11 then 0x22 -> data stays 8'h11 with valid=1, overrun pulses once; set ready=1 -> valid clears after one handshake.
REQ-032 N=8: apply a 2-cycle low glitch on rx while idle -> no state beyond START, no outputs; a subsequent 0xF0 frame is received.
REQ-033 N=1: assert RESET at the 5th data bit of 0xFF, release, then send 0x0F -> no output for the first frame; 8'h0F is delivered normally.
